// File: rtl/system_ecc_scrubber.sv
// system_ecc_scrubber
// Background scrubber for memory that holds 13-bit SECDED codewords from
// system_ecc_encoder. It walks every address, reads the word, and
// classifies it. Correctable words are written back fixed.
// Uncorrectable words are counted, their address is logged, and a sticky
// interrupt is raised. The memory port is shared with the functional path
// through an external arbiter using a req/gnt handshake.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   scrub_en           level enable; a word in flight always completes
//   clr_counts         synchronous clear of both counters and err_irq
//   mem_req/mem_we     registered request and direction (1 = write)
//   mem_addr           registered access address
//   mem_wdata          registered corrected codeword for write-back
//   mem_gnt            arbiter grant; an access is taken on mem_req & mem_gnt
//   mem_rvalid/rdata   read return, one or more cycles after the grant
//   busy               high outside IDLE/WAIT
//   pass_done          one-cycle pulse when the address wraps to 0
//   corr_count         saturating count of corrected words
//   uncorr_count       saturating count of uncorrectable words
//   last_uncorr_addr   address of the most recent uncorrectable word
//   err_irq            sticky, set on an uncorrectable word
module system_ecc_scrubber #(
  parameter int ADDR_WIDTH = 6,
  parameter int INTERVAL   = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scrub_en,
  input  logic                  clr_counts,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [12:0]           mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [12:0]           mem_rdata,
  output logic                  busy,
  output logic                  pass_done,
  output logic [CNT_WIDTH-1:0]  corr_count,
  output logic [CNT_WIDTH-1:0]  uncorr_count,
  output logic [ADDR_WIDTH-1:0] last_uncorr_addr,
  output logic                  err_irq
);

  // The timer holds INTERVAL-1 at most. It is never narrower than one bit.
  localparam int TIMER_WIDTH = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD = TIMER_WIDTH'(INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RD_REQ, S_RD_WAIT, S_CHECK, S_WR_REQ, S_NEXT
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [TIMER_WIDTH-1:0]  timer;
  logic [12:0]             rd_word;
  logic [3:0]              syn;
  logic                    pm;
  logic                    is_corr;
  logic                    is_uncorr;
  logic [12:0]             corrected;

  // Hamming positions are bit index + 1. Each syndrome bit covers the
  // positions that have the matching position bit set. The check bits sit
  // at bits 0, 1, 3 and 7, so the stored parity folds into the same XOR.
  assign syn[0] = ^{rd_word[0], rd_word[2], rd_word[4], rd_word[6], rd_word[8], rd_word[10]};
  assign syn[1] = ^{rd_word[1], rd_word[2], rd_word[5], rd_word[6], rd_word[9], rd_word[10]};
  assign syn[2] = ^{rd_word[3], rd_word[4], rd_word[5], rd_word[6], rd_word[11]};
  assign syn[3] = ^{rd_word[7], rd_word[8], rd_word[9], rd_word[10], rd_word[11]};
  assign pm     = ^rd_word;

  // Classify the captured word. Flipping a single bit is the correction.
  // A syndrome of 0 with odd overall parity means the parity bit itself
  // flipped. Syndromes 13..15 point outside the word and cannot be fixed.
  always_comb begin
    corrected = rd_word;
    is_corr   = 1'b0;
    is_uncorr = 1'b0;
    if (pm) begin
      if (syn == 4'd0) begin
        corrected[12] = ~rd_word[12];
        is_corr       = 1'b1;
      end else if (syn <= 4'd12) begin
        for (int i = 0; i < 12; i++) begin
          if (syn == 4'(i + 1)) corrected[i] = ~rd_word[i];
        end
        is_corr = 1'b1;
      end else begin
        is_uncorr = 1'b1;
      end
    end else if (syn != 4'd0) begin
      is_uncorr = 1'b1;
    end
  end

  // Next-state logic. scrub_en is only consulted in IDLE, WAIT and NEXT.
  // A word that has already started therefore runs to completion.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (scrub_en) state_next = S_WAIT;
      S_WAIT:    if (!scrub_en) state_next = S_IDLE;
                 else if (timer == '0) state_next = S_RD_REQ;
      S_RD_REQ:  if (mem_gnt) state_next = S_RD_WAIT;
      S_RD_WAIT: if (mem_rvalid) state_next = S_CHECK;
      S_CHECK:   state_next = is_corr ? S_WR_REQ : S_NEXT;
      S_WR_REQ:  if (mem_gnt) state_next = S_NEXT;
      S_NEXT:    state_next = scrub_en ? S_WAIT : S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_WAIT);

  // State, address walk and inter-access timer.
  // The timer is reloaded on every entry to WAIT, which gives INTERVAL
  // idle cycles between word accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      timer     <= '0;
      pass_done <= 1'b0;
    end else begin
      state     <= state_next;
      pass_done <= 1'b0;
      if ((state == S_IDLE && scrub_en) || state == S_NEXT) begin
        timer <= TIMER_LOAD;
      end else if (state == S_WAIT && timer != '0) begin
        timer <= timer - TIMER_WIDTH'(1);
      end
      if (state == S_NEXT) begin
        addr      <= addr + ADDR_WIDTH'(1);
        pass_done <= (addr == '1);
      end
    end
  end

  // The memory request is registered from the next state.
  // mem_req, mem_we, mem_addr and mem_wdata stay frozen while the arbiter
  // withholds the grant. Reset drops mem_req asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_word   <= '0;
    end else begin
      mem_req <= (state_next == S_RD_REQ) || (state_next == S_WR_REQ);
      mem_we  <= (state_next == S_WR_REQ);
      if (state_next == S_RD_REQ) mem_addr <= addr;
      if (state == S_RD_WAIT && mem_rvalid) rd_word <= mem_rdata;
      if (state == S_CHECK && is_corr) mem_wdata <= corrected;
    end
  end

  // Error logging. The counters saturate at all-ones.
  // A clear in the same cycle as an increment or an irq set wins.
  // last_uncorr_addr survives a clear so the location is still known.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_count       <= '0;
      uncorr_count     <= '0;
      last_uncorr_addr <= '0;
      err_irq          <= 1'b0;
    end else begin
      if (state == S_CHECK && is_uncorr) last_uncorr_addr <= addr;
      if (clr_counts) begin
        corr_count   <= '0;
        uncorr_count <= '0;
        err_irq      <= 1'b0;
      end else if (state == S_CHECK) begin
        if (is_corr && corr_count != '1) corr_count <= corr_count + CNT_WIDTH'(1);
        if (is_uncorr) begin
          err_irq <= 1'b1;
          if (uncorr_count != '1) uncorr_count <= uncorr_count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_system_ecc_scrubber.sv
// tb_system_ecc_scrubber
// Directed bench for system_ecc_scrubber with a 4-word memory (ADDR_WIDTH=2),
// INTERVAL=2 and 2-bit counters, so that counter saturation is reachable.
// A behavioural memory/arbiter responder takes accesses on mem_req & mem_gnt
// and returns read data one cycle after the grant.
// Codeword 13'h0A27 is the clean encoding of data 8'hA5.
module tb_system_ecc_scrubber;

  logic        clk;
  logic        rst_n;
  logic        scrub_en;
  logic        clr_counts;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_addr;
  logic [12:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [12:0] mem_rdata;
  logic        busy;
  logic        pass_done;
  logic [1:0]  corr_count;
  logic [1:0]  uncorr_count;
  logic [1:0]  last_uncorr_addr;
  logic        err_irq;

  system_ecc_scrubber #(.ADDR_WIDTH(2), .INTERVAL(2), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en), .clr_counts(clr_counts),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .pass_done(pass_done), .corr_count(corr_count),
    .uncorr_count(uncorr_count), .last_uncorr_addr(last_uncorr_addr), .err_irq(err_irq)
  );

  localparam logic [12:0] CLEAN = 13'h0A27;

  logic [12:0] mem [4];
  logic        pending_read;
  logic [1:0]  pending_addr;
  int          read_count;
  int          write_count;
  int          pass_count;
  int          last_rd_addr;
  int          last_wr_addr;
  int          last_wr_data;
  int          compared;
  int          mismatched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory and arbiter model. It runs on the falling edge.
  // An access is recorded when mem_req & mem_gnt, which is what the DUT
  // will see at the next rising edge. Read data is presented one cycle later.
  initial begin
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;
    pending_read = 1'b0;
    pending_addr = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        pending_read = 1'b0;
      end else begin
        if (pending_read) begin
          mem_rvalid   = 1'b1;
          mem_rdata    = mem[pending_addr];
          pending_read = 1'b0;
        end
        if (pass_done) pass_count++;
        if (mem_req && mem_gnt) begin
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            write_count++;
            last_wr_addr = int'(mem_addr);
            last_wr_data = int'(mem_wdata);
          end else begin
            pending_read = 1'b1;
            pending_addr = mem_addr;
            read_count++;
            last_rd_addr = int'(mem_addr);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearLogs();
    read_count  = 0;
    write_count = 0;
    pass_count  = 0;
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    scrub_en   = 1'b0;
    clr_counts = 1'b0;
    mem_gnt    = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulseClear();
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    @(negedge clk);
  endtask

  // Load the memory and run one full pass from address 0.
  // Scrubbing is disabled as soon as pass_done is seen, and the scrubber
  // must then settle back to idle.
  task automatic applyStimulus(input string tag, input logic [12:0] w0, input logic [12:0] w1,
                               input logic [12:0] w2, input logic [12:0] w3);
    int cyc;
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    clearLogs();
    scrub_en = 1'b1;
    cyc = 0;
    while (!pass_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    scrub_en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput({tag, " pass_done pulses"}, pass_count, 1);
    checkOutput({tag, " idle busy"}, 32'(busy), 0);
    checkOutput({tag, " reads"}, read_count, 4);
    checkOutput({tag, " last read addr"}, last_rd_addr, 3);
  endtask

  initial begin
    int  cyc;
    bit  found;
    compared     = 0;
    mismatched   = 0;
    last_rd_addr = 0;
    last_wr_addr = 0;
    last_wr_data = 0;
    clearLogs();
    for (int i = 0; i < 4; i++) mem[i] = CLEAN;

    // Reset state
    rst_n      = 1'b0;
    scrub_en   = 1'b0;
    clr_counts = 1'b0;
    mem_gnt    = 1'b1;
    #2;
    checkOutput("reset mem_req", 32'(mem_req), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset mem_wdata", 32'(mem_wdata), 0);
    checkOutput("reset corr_count", 32'(corr_count), 0);
    checkOutput("reset last_uncorr_addr", 32'(last_uncorr_addr), 0);
    checkOutput("reset err_irq", 32'(err_irq), 0);
    doReset();

    // Clean pass
    applyStimulus("clean", CLEAN, CLEAN, CLEAN, CLEAN);
    checkOutput("clean writes", write_count, 0);
    checkOutput("clean corr_count", 32'(corr_count), 0);
    checkOutput("clean uncorr_count", 32'(uncorr_count), 0);

    // Single data-bit error at addr 1 (bit 2 flipped, syndrome 3)
    applyStimulus("data err", CLEAN, 13'h0A23, CLEAN, CLEAN);
    checkOutput("data err writes", write_count, 1);
    checkOutput("data err write addr", last_wr_addr, 1);
    checkOutput("data err write data", last_wr_data, 32'h0A27);
    checkOutput("data err mem[1]", 32'(mem[1]), 32'h0A27);
    checkOutput("data err corr_count", 32'(corr_count), 1);
    checkOutput("data err err_irq", 32'(err_irq), 0);

    // Overall parity bit error at addr 2
    pulseClear();
    applyStimulus("parity err", CLEAN, CLEAN, 13'h1A27, CLEAN);
    checkOutput("parity err writes", write_count, 1);
    checkOutput("parity err write addr", last_wr_addr, 2);
    checkOutput("parity err write data", last_wr_data, 32'h0A27);
    checkOutput("parity err corr_count", 32'(corr_count), 1);

    // Double error at addr 3 (bits 2 and 4, syndrome 6, even parity)
    pulseClear();
    applyStimulus("double err", CLEAN, CLEAN, CLEAN, 13'h0A33);
    checkOutput("double err writes", write_count, 0);
    checkOutput("double err uncorr_count", 32'(uncorr_count), 1);
    checkOutput("double err corr_count", 32'(corr_count), 0);
    checkOutput("double err last addr", 32'(last_uncorr_addr), 3);
    checkOutput("double err err_irq", 32'(err_irq), 1);
    pulseClear();
    checkOutput("clear uncorr_count", 32'(uncorr_count), 0);
    checkOutput("clear err_irq", 32'(err_irq), 0);
    checkOutput("clear keeps last addr", 32'(last_uncorr_addr), 3);

    // Four corrections saturate a 2-bit counter at 3
    applyStimulus("saturate", 13'h0A23, 13'h0A23, 13'h0A23, 13'h0A23);
    checkOutput("saturate writes", write_count, 4);
    checkOutput("saturate corr_count", 32'(corr_count), 3);
    checkOutput("saturate mem[0]", 32'(mem[0]), 32'h0A27);

    // A clear held across the correction beats the increment
    pulseClear();
    clr_counts = 1'b1;
    applyStimulus("clear wins", CLEAN, 13'h0A23, CLEAN, CLEAN);
    clr_counts = 1'b0;
    checkOutput("clear wins writes", write_count, 1);
    checkOutput("clear wins corr_count", 32'(corr_count), 0);

    // Arbitration: withhold the grant for 5 cycles on the first read
    for (int i = 0; i < 4; i++) mem[i] = CLEAN;
    clearLogs();
    mem_gnt  = 1'b0;
    scrub_en = 1'b1;
    cyc = 0;
    while (!mem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("arb held mem_req", 32'(mem_req), 1);
      checkOutput("arb held mem_addr", 32'(mem_addr), 0);
      checkOutput("arb held mem_we", 32'(mem_we), 0);
      @(negedge clk);
    end
    checkOutput("arb no read before grant", read_count, 0);
    @(posedge clk);
    #1 mem_gnt = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("arb one read on grant", read_count, 1);
    checkOutput("arb req dropped", 32'(mem_req), 0);
    cyc = 0;
    while (!pass_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    scrub_en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("arb pass reads", read_count, 4);

    // Disable while in RD_WAIT, then resume at the next address
    doReset();
    for (int i = 0; i < 4; i++) mem[i] = CLEAN;
    clearLogs();
    scrub_en = 1'b1;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_req && !mem_we) found = 1'b1;
    end
    checkOutput("disable read seen", 32'(found), 1);
    @(posedge clk);
    #1 scrub_en = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("disable busy", 32'(busy), 0);
    checkOutput("disable reads", read_count, 1);
    checkOutput("disable read addr", last_rd_addr, 0);
    mem[1]   = 13'h0A23;
    scrub_en = 1'b1;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_req && !mem_we) found = 1'b1;
    end
    checkOutput("resume read seen", 32'(found), 1);
    checkOutput("resume addr", 32'(mem_addr), 1);

    // Reset asserted while the write-back request is pending
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_req && mem_we) found = 1'b1;
    end
    checkOutput("wr_req seen", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst mem_req", 32'(mem_req), 0);
    checkOutput("rst mem_we", 32'(mem_we), 0);
    checkOutput("rst mem_addr", 32'(mem_addr), 0);
    checkOutput("rst mem_wdata", 32'(mem_wdata), 0);
    checkOutput("rst busy", 32'(busy), 0);
    checkOutput("rst corr_count", 32'(corr_count), 0);
    checkOutput("rst pass_done", 32'(pass_done), 0);
    repeat (2) @(negedge clk);
    checkOutput("rst no write taken", write_count, 0);
    scrub_en = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
